// File: rtl/core_pkg.sv
// core_pkg: types and encodings shared by the three-stage RV32I core.
//   - wb_sel encodings for the writeback result mux
//   - forwarding select encodings driven back into EX
//   - base opcode localparams
//   - ctrl_t: the six per-instruction control bits carried EX -> WB
//   - pipe_state_e: the EX/WB register's stall state
//   - field helpers for pulling register indices out of an instruction
package core_pkg;

  typedef enum logic [1:0] {
    WB_PC4 = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_HELD = 2'b10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic reg_wr;
    logic mem_wr;
    logic mem_read;
    logic csr_reg_wr;
    logic csr_reg_r;
    logic is_mret;
  } ctrl_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } pipe_state_e;

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  // Results that only exist once WB has run (memory data, CSR read data)
  // cannot be forwarded into the instruction right behind them.
  function automatic logic is_late_sel(input logic [1:0] sel);
    return (sel == WB_MEM) || (sel == WB_CSR);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational load-use / CSR-read-use hazard detection
// and operand forwarding selects for the EX stage.
// Ports:
//   run          in   pipeline register is in RUN (not already stalling)
//   flush        in   branch or trap redirect this cycle
//   wb_valid     in   WB holds a real instruction
//   wb_reg_wr    in   WB instruction writes a register
//   wb_sel       in   WB result source
//   wb_rd        in   WB destination register
//   held_rd      in   destination of the previous WB instruction (0 = none)
//   rs1, rs2     in   EX source registers
//   rs1_used     in   EX instruction reads rs1
//   rs2_used     in   EX instruction reads rs2
//   stall        out  hold PC and IF/EX this cycle
//   fwd_a, fwd_b out  operand select (FWD_RF / FWD_WB / FWD_HELD)
module hazard_fwd_unit
  import core_pkg::*;
(
  input  logic       run,
  input  logic       flush,
  input  logic       wb_valid,
  input  logic       wb_reg_wr,
  input  logic [1:0] wb_sel,
  input  logic [4:0] wb_rd,
  input  logic [4:0] held_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic            wb_writes;
  logic            wb_late;
  logic            hazard;
  logic [1:0][4:0] rs_idx;
  logic [1:0]      rs_used;
  logic [1:0]      use_hit;
  logic [1:0][1:0] fwd_sel;

  // wb_rd != 0 also keeps x0 sources on the register file.
  assign wb_writes = wb_valid & wb_reg_wr & (wb_rd != 5'd0);
  assign wb_late   = is_late_sel(wb_sel);

  assign rs_idx  = {rs2, rs1};
  assign rs_used = {rs2_used, rs1_used};

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    // A hazard only matters for operands the instruction actually reads.
    assign use_hit[gi] = rs_used[gi] & (rs_idx[gi] == wb_rd);

    // WB result wins over the held one: it is the younger write.
    assign fwd_sel[gi] =
        (wb_writes && !wb_late && rs_idx[gi] == wb_rd)  ? FWD_WB   :
        (held_rd != 5'd0 && rs_idx[gi] == held_rd)      ? FWD_HELD :
                                                          FWD_RF;
  end

  // Gating on run bounds every stall to a single cycle: after the bubble the
  // producer has moved to the held slot and is reachable through FWD_HELD.
  assign hazard = run & wb_writes & wb_late & (|use_hit);
  assign stall  = hazard & ~flush;

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

endmodule

// File: rtl/ex_wb_pipe.sv
// ex_wb_pipe: EX -> WB/MEM pipeline register of the three-stage RV32I core.
// Captures EX results and controls, turns them into bubbles on a redirect or
// a load/CSR-use stall, keeps the previous WB result for forwarding, and
// drives operand forwarding selects back into EX.
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   ex_*                  EX-stage instruction fields and controls
//   interrupt_in          raw interrupt lines, registered every cycle
//   br_taken, epc_taken   branch/jump redirect (EX), trap/mret redirect (WB)
//   wb_wdata              current WB result, fed back for forwarding
//   wb_*                  registered EX fields; controls zeroed on bubbles
//   wb_valid              WB holds a real instruction
//   stall                 combinational; hold PC and IF/EX this cycle
//   fwd_a, fwd_b          operand selects: 00 regfile, 01 wb_wdata, 10 held
//   fwd_held_data         result of the previous WB instruction
module ex_wb_pipe
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [31:0]        ex_instruction,
  input  logic [XLEN-1:0]    ex_alu_o,
  input  logic [XLEN-1:0]    ex_data_to_mem,
  input  logic [XLEN-1:0]    ex_rdata1,
  input  logic [1:0]         ex_wb_sel,
  input  logic               ex_reg_wr,
  input  logic               ex_mem_wr,
  input  logic               ex_mem_read,
  input  logic               ex_csr_reg_wr,
  input  logic               ex_csr_reg_r,
  input  logic               ex_is_mret,
  input  logic               ex_rs1_used,
  input  logic               ex_rs2_used,
  input  logic [NUM_IRQ-1:0] interrupt_in,
  input  logic               br_taken,
  input  logic               epc_taken,
  input  logic [XLEN-1:0]    wb_wdata,
  output logic [XLEN-1:0]    wb_pc,
  output logic [31:0]        wb_instruction,
  output logic [XLEN-1:0]    wb_alu_o,
  output logic [XLEN-1:0]    wb_data_to_mem,
  output logic [XLEN-1:0]    wb_rdata1,
  output logic [1:0]         wb_wb_sel,
  output logic               wb_reg_wr,
  output logic               wb_mem_wr,
  output logic               wb_mem_read,
  output logic               wb_csr_reg_wr,
  output logic               wb_csr_reg_r,
  output logic               wb_is_mret,
  output logic [NUM_IRQ-1:0] wb_interrupt,
  output logic               wb_valid,
  output logic               stall,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [XLEN-1:0]    fwd_held_data
);

  pipe_state_e         state_reg;
  ctrl_t               ctrl_reg;
  ctrl_t               ex_ctrl;
  logic [XLEN-1:0]     pc_reg;
  logic [31:0]         instr_reg;
  logic [XLEN-1:0]     alu_reg;
  logic [XLEN-1:0]     store_data_reg;
  logic [XLEN-1:0]     rdata1_reg;
  logic [1:0]          wb_sel_reg;
  logic [NUM_IRQ-1:0]  irq_reg;
  logic                valid_reg;
  logic [XLEN-1:0]     held_data_reg;
  logic [4:0]          held_rd_reg;
  logic                flush;
  logic [4:0]          wb_rd;

  assign flush = br_taken | epc_taken;
  assign wb_rd = rd_of(instr_reg);

  assign ex_ctrl = '{
    reg_wr:     ex_reg_wr,
    mem_wr:     ex_mem_wr,
    mem_read:   ex_mem_read,
    csr_reg_wr: ex_csr_reg_wr,
    csr_reg_r:  ex_csr_reg_r,
    is_mret:    ex_is_mret
  };

  hazard_fwd_unit u_hazard_fwd (
    .run      (state_reg == ST_RUN),
    .flush    (flush),
    .wb_valid (valid_reg),
    .wb_reg_wr(ctrl_reg.reg_wr),
    .wb_sel   (wb_sel_reg),
    .wb_rd    (wb_rd),
    .held_rd  (held_rd_reg),
    .rs1      (rs1_of(ex_instruction)),
    .rs2      (rs2_of(ex_instruction)),
    .rs1_used (ex_rs1_used),
    .rs2_used (ex_rs2_used),
    .stall    (stall),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_RUN;
      ctrl_reg       <= '0;
      pc_reg         <= '0;
      instr_reg      <= '0;
      alu_reg        <= '0;
      store_data_reg <= '0;
      rdata1_reg     <= '0;
      wb_sel_reg     <= '0;
      irq_reg        <= '0;
      valid_reg      <= 1'b0;
      held_data_reg  <= '0;
      held_rd_reg    <= '0;
    end else begin
      // Interrupt lines are sampled every cycle; bubbles do not mask them.
      irq_reg <= interrupt_in;

      // The instruction leaving WB becomes the held forwarding source.
      if (valid_reg && ctrl_reg.reg_wr) begin
        held_data_reg <= wb_wdata;
        held_rd_reg   <= wb_rd;
      end else begin
        held_rd_reg <= '0;
      end

      if (flush) begin
        // Data fields are don't-care once invalid, so they load normally.
        pc_reg         <= ex_pc;
        instr_reg      <= ex_instruction;
        alu_reg        <= ex_alu_o;
        store_data_reg <= ex_data_to_mem;
        rdata1_reg     <= ex_rdata1;
        wb_sel_reg     <= ex_wb_sel;
        ctrl_reg       <= '0;
        valid_reg      <= 1'b0;
        state_reg      <= ST_RUN;
      end else if (stall) begin
        // Bubble: data fields keep their old value, controls go quiet.
        ctrl_reg  <= '0;
        valid_reg <= 1'b0;
        state_reg <= ST_STALL;
      end else begin
        pc_reg         <= ex_pc;
        instr_reg      <= ex_instruction;
        alu_reg        <= ex_alu_o;
        store_data_reg <= ex_data_to_mem;
        rdata1_reg     <= ex_rdata1;
        wb_sel_reg     <= ex_wb_sel;
        ctrl_reg       <= ex_ctrl;
        valid_reg      <= 1'b1;
        state_reg      <= ST_RUN;
      end
    end
  end

  assign wb_pc          = pc_reg;
  assign wb_instruction = instr_reg;
  assign wb_alu_o       = alu_reg;
  assign wb_data_to_mem = store_data_reg;
  assign wb_rdata1      = rdata1_reg;
  assign wb_wb_sel      = wb_sel_reg;
  assign wb_reg_wr      = ctrl_reg.reg_wr;
  assign wb_mem_wr      = ctrl_reg.mem_wr;
  assign wb_mem_read    = ctrl_reg.mem_read;
  assign wb_csr_reg_wr  = ctrl_reg.csr_reg_wr;
  assign wb_csr_reg_r   = ctrl_reg.csr_reg_r;
  assign wb_is_mret     = ctrl_reg.is_mret;
  assign wb_interrupt   = irq_reg;
  assign wb_valid       = valid_reg;
  assign fwd_held_data  = held_data_reg;

endmodule

// File: tb/tb_ex_wb_pipe.sv
// tb_ex_wb_pipe: directed scenarios for ex_wb_pipe with hand-computed
// expectations, one task per scenario, one line per failed comparison.
module tb_ex_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_pc, ex_instruction, ex_alu_o, ex_data_to_mem, ex_rdata1;
  logic [1:0]  ex_wb_sel;
  logic        ex_reg_wr, ex_mem_wr, ex_mem_read, ex_csr_reg_wr, ex_csr_reg_r, ex_is_mret;
  logic        ex_rs1_used, ex_rs2_used;
  logic [3:0]  interrupt_in;
  logic        br_taken, epc_taken;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc, wb_instruction, wb_alu_o, wb_data_to_mem, wb_rdata1;
  logic [1:0]  wb_wb_sel;
  logic        wb_reg_wr, wb_mem_wr, wb_mem_read, wb_csr_reg_wr, wb_csr_reg_r, wb_is_mret;
  logic [3:0]  wb_interrupt;
  logic        wb_valid, stall;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] fwd_held_data;

  int checks = 0;
  int passed = 0;

  // control vectors: {reg_wr, mem_wr, mem_read, csr_reg_wr, csr_reg_r, is_mret}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_ALU   = 6'b100000;
  localparam logic [5:0] C_LOAD  = 6'b101000;
  localparam logic [5:0] C_STORE = 6'b010000;
  localparam logic [5:0] C_CSR   = 6'b100010;
  localparam logic [1:0] S_PC4 = 2'b00, S_ALU = 2'b01, S_MEM = 2'b10, S_CSR = 2'b11;

  always #5 clk = ~clk;

  ex_wb_pipe #(.XLEN(32), .NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst),
    .ex_pc(ex_pc), .ex_instruction(ex_instruction), .ex_alu_o(ex_alu_o),
    .ex_data_to_mem(ex_data_to_mem), .ex_rdata1(ex_rdata1), .ex_wb_sel(ex_wb_sel),
    .ex_reg_wr(ex_reg_wr), .ex_mem_wr(ex_mem_wr), .ex_mem_read(ex_mem_read),
    .ex_csr_reg_wr(ex_csr_reg_wr), .ex_csr_reg_r(ex_csr_reg_r), .ex_is_mret(ex_is_mret),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .interrupt_in(interrupt_in), .br_taken(br_taken), .epc_taken(epc_taken),
    .wb_wdata(wb_wdata),
    .wb_pc(wb_pc), .wb_instruction(wb_instruction), .wb_alu_o(wb_alu_o),
    .wb_data_to_mem(wb_data_to_mem), .wb_rdata1(wb_rdata1), .wb_wb_sel(wb_wb_sel),
    .wb_reg_wr(wb_reg_wr), .wb_mem_wr(wb_mem_wr), .wb_mem_read(wb_mem_read),
    .wb_csr_reg_wr(wb_csr_reg_wr), .wb_csr_reg_r(wb_csr_reg_r), .wb_is_mret(wb_is_mret),
    .wb_interrupt(wb_interrupt), .wb_valid(wb_valid), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_held_data(fwd_held_data)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] alu, input logic [1:0] sel,
                          input logic [5:0] ctl, input logic [1:0] used);
    ex_pc = pc;
    ex_instruction = instr;
    ex_alu_o = alu;
    ex_data_to_mem = alu ^ 32'h5555_5555;
    ex_rdata1 = pc + 32'd1;
    ex_wb_sel = sel;
    {ex_reg_wr, ex_mem_wr, ex_mem_read, ex_csr_reg_wr, ex_csr_reg_r, ex_is_mret} = ctl;
    {ex_rs1_used, ex_rs2_used} = used;
  endtask

  // Two plain non-writing nops drain WB and the held slot.
  task automatic idle;
    br_taken = 1'b0;
    epc_taken = 1'b0;
    wb_wdata = 32'd0;
    drive_ex(32'h0, addi(5'd0, 5'd0, 12'd0), 32'd0, S_ALU, C_NONE, 2'b00);
    repeat (2) tick;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    br_taken = 1'b0;
    epc_taken = 1'b0;
    wb_wdata = 32'h1234_5678;
    interrupt_in = 4'b1010;
    drive_ex(32'h100, addi(5'd1, 5'd0, 12'd1), 32'd1, S_ALU, C_ALU, 2'b10);
    repeat (2) tick;
    checks++; if (wb_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", wb_valid); else passed++;
    checks++; if (wb_reg_wr !== 1'b0) $display("FAIL rst_reg_wr got=%b exp=0", wb_reg_wr); else passed++;
    checks++; if (wb_pc !== 32'd0) $display("FAIL rst_pc got=%h exp=0", wb_pc); else passed++;
    checks++; if (wb_instruction !== 32'd0) $display("FAIL rst_instr got=%h exp=0", wb_instruction); else passed++;
    checks++; if (wb_interrupt !== 4'd0) $display("FAIL rst_irq got=%b exp=0000", wb_interrupt); else passed++;
    checks++; if (fwd_held_data !== 32'd0) $display("FAIL rst_held got=%h exp=0", fwd_held_data); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall); else passed++;
    rst = 1'b1;
    tick;
    checks++; if (wb_valid !== 1'b1) $display("FAIL first_valid got=%b exp=1", wb_valid); else passed++;
    checks++; if (wb_pc !== 32'h100) $display("FAIL first_pc got=%h exp=00000100", wb_pc); else passed++;
    checks++; if (wb_reg_wr !== 1'b1) $display("FAIL first_reg_wr got=%b exp=1", wb_reg_wr); else passed++;
    checks++; if (wb_interrupt !== 4'b1010) $display("FAIL first_irq got=%b exp=1010", wb_interrupt); else passed++;
    interrupt_in = 4'b0000;
  endtask

  task automatic test_alu_fwd;
    idle;
    drive_ex(32'h200, addi(5'd5, 5'd0, 12'd7), 32'd7, S_ALU, C_ALU, 2'b10);
    tick;
    wb_wdata = 32'd7;
    drive_ex(32'h204, enc_r(5'd5, 5'd5, 5'd6), 32'd14, S_ALU, C_ALU, 2'b11);
    #1;
    checks++; if (fwd_a !== 2'b01) $display("FAIL alu_fwd_a got=%b exp=01", fwd_a); else passed++;
    checks++; if (fwd_b !== 2'b01) $display("FAIL alu_fwd_b got=%b exp=01", fwd_b); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL alu_stall got=%b exp=0", stall); else passed++;
    tick;
    checks++; if (wb_alu_o !== 32'd14) $display("FAIL alu_capture got=%h exp=0000000e", wb_alu_o); else passed++;
    checks++; if (wb_data_to_mem !== (32'd14 ^ 32'h5555_5555)) $display("FAIL alu_store_data got=%h", wb_data_to_mem); else passed++;
    checks++; if (wb_rdata1 !== 32'h205) $display("FAIL alu_rdata1 got=%h exp=00000205", wb_rdata1); else passed++;
  endtask

  task automatic test_fwd_priority;
    idle;
    drive_ex(32'h300, addi(5'd5, 5'd0, 12'd7), 32'd7, S_ALU, C_ALU, 2'b10);
    tick;
    wb_wdata = 32'd7;
    drive_ex(32'h304, addi(5'd5, 5'd5, 12'd1), 32'd8, S_ALU, C_ALU, 2'b10);
    #1;
    checks++; if (fwd_a !== 2'b01) $display("FAIL pri_wb_only got=%b exp=01", fwd_a); else passed++;
    tick;
    wb_wdata = 32'd8;
    drive_ex(32'h308, enc_r(5'd5, 5'd5, 5'd6), 32'd16, S_ALU, C_ALU, 2'b11);
    #1;
    checks++; if (fwd_a !== 2'b01) $display("FAIL pri_wb_over_held got=%b exp=01", fwd_a); else passed++;
    tick;
    wb_wdata = 32'd16;
    drive_ex(32'h30c, enc_r(5'd5, 5'd5, 5'd7), 32'd16, S_ALU, C_ALU, 2'b11);
    #1;
    checks++; if (fwd_a !== 2'b10) $display("FAIL pri_held_a got=%b exp=10", fwd_a); else passed++;
    checks++; if (fwd_b !== 2'b10) $display("FAIL pri_held_b got=%b exp=10", fwd_b); else passed++;
    checks++; if (fwd_held_data !== 32'd8) $display("FAIL pri_held_data got=%h exp=00000008", fwd_held_data); else passed++;
    tick;
  endtask

  task automatic test_load_use;
    idle;
    drive_ex(32'h400, lw(5'd7, 5'd1, 12'd0), 32'h1000, S_MEM, C_LOAD, 2'b10);
    tick;
    checks++; if (wb_mem_read !== 1'b1) $display("FAIL lu_mem_read got=%b exp=1", wb_mem_read); else passed++;
    wb_wdata = 32'hDEADBEEF;
    drive_ex(32'h404, addi(5'd8, 5'd7, 12'd1), 32'd0, S_ALU, C_ALU, 2'b10);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL lu_stall got=%b exp=1", stall); else passed++;
    tick;
    wb_wdata = 32'd0;
    #1;
    checks++; if (wb_valid !== 1'b0) $display("FAIL lu_bubble_valid got=%b exp=0", wb_valid); else passed++;
    checks++; if (wb_reg_wr !== 1'b0) $display("FAIL lu_bubble_reg_wr got=%b exp=0", wb_reg_wr); else passed++;
    checks++; if (wb_mem_read !== 1'b0) $display("FAIL lu_bubble_mem_read got=%b exp=0", wb_mem_read); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL lu_one_cycle got=%b exp=0", stall); else passed++;
    checks++; if (fwd_a !== 2'b10) $display("FAIL lu_fwd_a got=%b exp=10", fwd_a); else passed++;
    checks++; if (fwd_b !== 2'b00) $display("FAIL lu_fwd_b got=%b exp=00", fwd_b); else passed++;
    checks++; if (fwd_held_data !== 32'hDEADBEEF) $display("FAIL lu_held_data got=%h exp=deadbeef", fwd_held_data); else passed++;
    tick;
    checks++; if (wb_valid !== 1'b1) $display("FAIL lu_resume_valid got=%b exp=1", wb_valid); else passed++;
    checks++; if (wb_pc !== 32'h404) $display("FAIL lu_resume_pc got=%h exp=00000404", wb_pc); else passed++;
  endtask

  task automatic test_back_to_back;
    idle;
    drive_ex(32'h500, lw(5'd7, 5'd1, 12'd0), 32'h1000, S_MEM, C_LOAD, 2'b10);
    tick;
    wb_wdata = 32'h0000_2000;
    drive_ex(32'h504, lw(5'd10, 5'd7, 12'd0), 32'h2000, S_MEM, C_LOAD, 2'b10);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL b2b_stall1 got=%b exp=1", stall); else passed++;
    tick;
    wb_wdata = 32'd0;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL b2b_release1 got=%b exp=0", stall); else passed++;
    tick;
    wb_wdata = 32'h0000_0055;
    drive_ex(32'h508, addi(5'd11, 5'd10, 12'd1), 32'd0, S_ALU, C_ALU, 2'b10);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL b2b_stall2 got=%b exp=1", stall); else passed++;
    tick;
    wb_wdata = 32'd0;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL b2b_release2 got=%b exp=0", stall); else passed++;
    checks++; if (fwd_held_data !== 32'h55) $display("FAIL b2b_held got=%h exp=00000055", fwd_held_data); else passed++;
    tick;
  endtask

  task automatic test_csr_use;
    idle;
    drive_ex(32'h600, enc_i(12'h300, 5'd0, 3'b010, 5'd13, 7'b1110011), 32'd0, S_CSR, C_CSR, 2'b10);
    tick;
    wb_wdata = 32'h0000_1800;
    drive_ex(32'h604, enc_r(5'd13, 5'd2, 5'd14), 32'd0, S_ALU, C_ALU, 2'b11);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL csr_stall got=%b exp=1", stall); else passed++;
    checks++; if (wb_csr_reg_r !== 1'b1) $display("FAIL csr_reg_r got=%b exp=1", wb_csr_reg_r); else passed++;
    tick;
    tick;
  endtask

  task automatic test_flush_priority;
    idle;
    drive_ex(32'h700, lw(5'd7, 5'd1, 12'd0), 32'h1000, S_MEM, C_LOAD, 2'b10);
    tick;
    wb_wdata = 32'h1111_2222;
    drive_ex(32'h704, enc_s(12'd4, 5'd7, 5'd2), 32'h1004, S_PC4, C_STORE, 2'b11);
    br_taken = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_no_stall got=%b exp=0", stall); else passed++;
    tick;
    br_taken = 1'b0;
    checks++; if (wb_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", wb_valid); else passed++;
    checks++; if (wb_mem_wr !== 1'b0) $display("FAIL flush_mem_wr got=%b exp=0", wb_mem_wr); else passed++;
    wb_wdata = 32'd0;
    drive_ex(32'h800, addi(5'd8, 5'd7, 12'd1), 32'd0, S_ALU, C_ALU, 2'b10);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_after_stall got=%b exp=0", stall); else passed++;
    tick;
    checks++; if (wb_valid !== 1'b1) $display("FAIL flush_run_valid got=%b exp=1", wb_valid); else passed++;
  endtask

  task automatic test_trap_in_stall;
    idle;
    drive_ex(32'h900, lw(5'd7, 5'd1, 12'd0), 32'h1000, S_MEM, C_LOAD, 2'b10);
    tick;
    wb_wdata = 32'hCAFE_0001;
    drive_ex(32'h904, addi(5'd8, 5'd7, 12'd1), 32'd0, S_ALU, C_ALU, 2'b10);
    interrupt_in = 4'b0110;
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL trap_stall got=%b exp=1", stall); else passed++;
    tick;
    checks++; if (wb_interrupt !== 4'b0110) $display("FAIL trap_irq got=%b exp=0110", wb_interrupt); else passed++;
    wb_wdata = 32'd0;
    epc_taken = 1'b1;
    drive_ex(32'h908, addi(5'd8, 5'd7, 12'd1), 32'd0, S_ALU, C_ALU, 2'b10);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL trap_no_stall got=%b exp=0", stall); else passed++;
    tick;
    epc_taken = 1'b0;
    interrupt_in = 4'b0000;
    checks++; if (wb_valid !== 1'b0) $display("FAIL trap_bubble got=%b exp=0", wb_valid); else passed++;
    drive_ex(32'h1c0, addi(5'd12, 5'd7, 12'd2), 32'd0, S_ALU, C_ALU, 2'b10);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL trap_no_second got=%b exp=0", stall); else passed++;
    tick;
    checks++; if (wb_valid !== 1'b1) $display("FAIL trap_run_valid got=%b exp=1", wb_valid); else passed++;
    checks++; if (wb_pc !== 32'h1c0) $display("FAIL trap_run_pc got=%h exp=000001c0", wb_pc); else passed++;
  endtask

  task automatic test_x0_dest;
    idle;
    drive_ex(32'hA00, lw(5'd0, 5'd1, 12'd0), 32'h1000, S_MEM, C_LOAD, 2'b10);
    tick;
    wb_wdata = 32'h7777_7777;
    drive_ex(32'hA04, enc_r(5'd0, 5'd0, 5'd9), 32'd0, S_ALU, C_ALU, 2'b11);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL x0_stall got=%b exp=0", stall); else passed++;
    checks++; if (fwd_a !== 2'b00) $display("FAIL x0_fwd_a got=%b exp=00", fwd_a); else passed++;
    checks++; if (fwd_b !== 2'b00) $display("FAIL x0_fwd_b got=%b exp=00", fwd_b); else passed++;
    tick;
    checks++; if (wb_valid !== 1'b1) $display("FAIL x0_valid got=%b exp=1", wb_valid); else passed++;
  endtask

  task automatic test_reset_in_stall;
    idle;
    drive_ex(32'hB00, lw(5'd7, 5'd1, 12'd0), 32'h1000, S_MEM, C_LOAD, 2'b10);
    tick;
    wb_wdata = 32'hABCD_0000;
    drive_ex(32'hB04, addi(5'd8, 5'd7, 12'd1), 32'd0, S_ALU, C_ALU, 2'b10);
    tick;
    rst = 1'b0;
    tick;
    checks++; if (wb_valid !== 1'b0) $display("FAIL rst_stall_valid got=%b exp=0", wb_valid); else passed++;
    checks++; if (wb_pc !== 32'd0) $display("FAIL rst_stall_pc got=%h exp=0", wb_pc); else passed++;
    checks++; if (fwd_held_data !== 32'd0) $display("FAIL rst_stall_held got=%h exp=0", fwd_held_data); else passed++;
    checks++; if (fwd_a !== 2'b00) $display("FAIL rst_stall_fwd got=%b exp=00", fwd_a); else passed++;
    rst = 1'b1;
    tick;
    checks++; if (wb_valid !== 1'b1) $display("FAIL rst_stall_run got=%b exp=1", wb_valid); else passed++;
  endtask

  initial begin
    test_reset;
    test_alu_fwd;
    test_fwd_priority;
    test_load_use;
    test_back_to_back;
    test_csr_use;
    test_flush_priority;
    test_trap_in_stall;
    test_x0_dest;
    test_reset_in_stall;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
